emu_step_ctrl: RTL and testbench

EMU_STEP_CTRL -- requirements
Module: emu_step_ctrl

---
 rtl/emu_step_ctrl.sv | 139 +++++++++++++
 tb/tb_emu_step_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_step_ctrl.sv
// Emulation step controller: optionally resets the model, issues N one-cycle step
// enables with SETTLE idle cycles after each, then captures the model output.
module emu_step_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 25,
  parameter int SETTLE     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         init_i,
  input  logic                         abort_i,
  input  logic        [CNT_WIDTH-1:0]  n_steps_i,
  input  logic signed [DATA_WIDTH-1:0] v_in_i,
  input  logic signed [DATA_WIDTH-1:0] v_out_i,
  output logic                         model_rst_o,
  output logic                         model_ce_o,
  output logic signed [DATA_WIDTH-1:0] v_in_o,
  output logic signed [DATA_WIDTH-1:0] v_out_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         aborted_o,
  output logic        [CNT_WIDTH-1:0]  steps_done_o
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] WAIT_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_MRST, S_STEP, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]           wait_q, wait_d;
  logic                    mrst_ph_q, mrst_ph_d;
  logic signed [DATA_WIDTH-1:0] v_in_q, v_in_d;
  logic signed [DATA_WIDTH-1:0] v_out_q, v_out_d;
  logic                    aborted_d;
  logic                    model_rst_q, model_ce_q, busy_q, done_q, aborted_q;
  logic                    step_more;

  // Evaluated in STEP, so it looks at the count after this step is taken.
  assign step_more = ({1'b0, cnt_q} + (CNT_WIDTH + 1)'(1)) < {1'b0, n_q};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    mrst_ph_d = mrst_ph_q;
    v_in_d    = v_in_q;
    v_out_d   = v_out_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          n_d       = n_steps_i;
          v_in_d    = v_in_i;
          cnt_d     = '0;
          mrst_ph_d = 1'b0;
          if (init_i)                state_d = S_MRST;
          else if (n_steps_i != '0)  state_d = S_STEP;
          else                       state_d = S_CAPTURE;
        end
      end
      S_MRST: begin
        if (mrst_ph_q) state_d = (n_q != '0) ? S_STEP : S_CAPTURE;
        else           mrst_ph_d = 1'b1;
      end
      S_STEP: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (SETTLE == 0) begin
          state_d = step_more ? S_STEP : S_CAPTURE;
        end else begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = (cnt_q < n_q) ? S_STEP : S_CAPTURE;
        else                     wait_d  = wait_q + SW'(1);
      end
      S_CAPTURE: begin
        v_out_d = v_out_i;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort keeps any step already issued this cycle but discards a capture.
    if (state_q != S_IDLE && abort_i) begin
      state_d   = S_IDLE;
      v_out_d   = v_out_q;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      mrst_ph_q   <= 1'b0;
      v_in_q      <= '0;
      v_out_q     <= '0;
      model_rst_q <= 1'b1;
      model_ce_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      mrst_ph_q   <= mrst_ph_d;
      v_in_q      <= v_in_d;
      v_out_q     <= v_out_d;
      model_rst_q <= (state_d == S_MRST);
      model_ce_q  <= (state_d == S_STEP);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      aborted_q   <= aborted_d;
    end
  end

  assign model_rst_o  = model_rst_q;
  assign model_ce_o   = model_ce_q;
  assign v_in_o       = v_in_q;
  assign v_out_o      = v_out_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign steps_done_o = cnt_q;

endmodule

// File: tb/tb_emu_step_ctrl.sv
// Bench for emu_step_ctrl: two instances (SETTLE=2 and SETTLE=0) share stimulus and are
// compared cycle by cycle against a timing model derived from the run rules.
module tb_emu_step_ctrl;
  localparam int CW = 16;
  localparam int DW = 25;

  logic clk = 1'b0;
  logic rst, start_i, init_i, abort_i;
  logic [CW-1:0] n_steps_i;
  logic signed [DW-1:0] v_in_i, v_out_i;

  logic a_mrst, a_ce, a_busy, a_done, a_abt;
  logic b_mrst, b_ce, b_busy, b_done, b_abt;
  logic signed [DW-1:0] a_vin, a_vout, b_vin, b_vout;
  logic [CW-1:0] a_steps, b_steps;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic signed [DW-1:0] exp_vout_a = '0;
  logic signed [DW-1:0] exp_vout_b = '0;

  always #5 clk = ~clk;

  emu_step_ctrl #(.CNT_WIDTH(CW), .DATA_WIDTH(DW), .SETTLE(2)) u_a (
    .clk(clk), .rst(rst), .start_i(start_i), .init_i(init_i), .abort_i(abort_i),
    .n_steps_i(n_steps_i), .v_in_i(v_in_i), .v_out_i(v_out_i),
    .model_rst_o(a_mrst), .model_ce_o(a_ce), .v_in_o(a_vin), .v_out_o(a_vout),
    .busy_o(a_busy), .done_o(a_done), .aborted_o(a_abt), .steps_done_o(a_steps));

  emu_step_ctrl #(.CNT_WIDTH(CW), .DATA_WIDTH(DW), .SETTLE(0)) u_b (
    .clk(clk), .rst(rst), .start_i(start_i), .init_i(init_i), .abort_i(abort_i),
    .n_steps_i(n_steps_i), .v_in_i(v_in_i), .v_out_i(v_out_i),
    .model_rst_o(b_mrst), .model_ce_o(b_ce), .v_in_o(b_vin), .v_out_o(b_vout),
    .busy_o(b_busy), .done_o(b_done), .aborted_o(b_abt), .steps_done_o(b_steps));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge; on return the bench sits in cycle 1.
  task automatic launch(input int n, input bit init, input logic signed [DW-1:0] vin);
    n_steps_i = CW'(n);
    init_i    = init;
    v_in_i    = vin;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    init_i    = 1'b0;
  endtask

  // Expected {model_rst, ce, busy, done, aborted, steps, v_in, v_out} in cycle t of a run.
  function automatic logic [70:0] model(input int s, input int t, input int n, input bit init,
                                        input logic signed [DW-1:0] vin,
                                        input logic signed [DW-1:0] vout);
    int off = init ? 2 : 0;
    int k   = t - off - 1;
    int dn  = off + 2 + n * (s + 1);
    int st;
    bit ce  = (t > off) && (k % (s + 1) == 0) && (k / (s + 1) < n);
    st = (t <= off + 1) ? 0 : ((t - off - 2) / (s + 1) + 1);
    if (st > n) st = n;
    return {(init && t <= 2), ce, (t <= dn), (t == dn), 1'b0, CW'(st), vin, vout};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; init_i = 1'b0; abort_i = 1'b0;
    n_steps_i = '0; v_in_i = '0; v_out_i = '0;
    tick(); tick();
    chk_cnt++;
    if ({a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout} !== {5'b10000, 66'd0}) begin
      $display("FAIL reset_a got %h want %h",
               {a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout}, {5'b10000, 66'd0});
    end else pass_cnt++;
    chk_cnt++;
    if ({b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout} !== {5'b10000, 66'd0}) begin
      $display("FAIL reset_b got %h want %h",
               {b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout}, {5'b10000, 66'd0});
    end else pass_cnt++;
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({a_mrst, b_mrst, a_busy, b_busy} !== 4'b0000) begin
      $display("FAIL reset_release got %b want 0000", {a_mrst, b_mrst, a_busy, b_busy});
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] ce_a = '0, dn_a = '0, ce_b = '0, dn_b = '0;
    launch(3, 1'b0, 25'sd100);
    for (int t = 1; t < 20; t++) begin
      ce_a[t] = a_ce; dn_a[t] = a_done; ce_b[t] = b_ce; dn_b[t] = b_done;
      v_out_i = DW'($urandom);
      if (t == 10) exp_vout_a = v_out_i;
      if (t == 4)  exp_vout_b = v_out_i;
      tick();
    end
    chk_cnt++;
    if ({ce_a, dn_a} !== {32'h0000_0092, 32'h0000_0800}) begin
      $display("FAIL basic_timing_a got ce=%h done=%h want ce=00000092 done=00000800", ce_a, dn_a);
    end else pass_cnt++;
    chk_cnt++;
    if ({ce_b, dn_b} !== {32'h0000_000E, 32'h0000_0020}) begin
      $display("FAIL basic_timing_b got ce=%h done=%h want ce=0000000e done=00000020", ce_b, dn_b);
    end else pass_cnt++;
    chk_cnt++;
    if ({a_steps, a_vin, a_vout} !== {16'd3, 25'sd100, exp_vout_a}) begin
      $display("FAIL basic_result_a got %h want %h",
               {a_steps, a_vin, a_vout}, {16'd3, 25'sd100, exp_vout_a});
    end else pass_cnt++;
    chk_cnt++;
    if ({b_steps, b_vout} !== {16'd3, exp_vout_b}) begin
      $display("FAIL basic_result_b got %h want %h", {b_steps, b_vout}, {16'd3, exp_vout_b});
    end else pass_cnt++;
  endtask

  task automatic test_init();
    logic [31:0] mr_a = '0, ce_a = '0, dn_a = '0, mr_b = '0, dn_b = '0;
    launch(1, 1'b1, -25'sd7);
    for (int t = 1; t < 12; t++) begin
      mr_a[t] = a_mrst; ce_a[t] = a_ce; dn_a[t] = a_done; mr_b[t] = b_mrst; dn_b[t] = b_done;
      v_out_i = DW'($urandom);
      if (t == 6) exp_vout_a = v_out_i;
      if (t == 4) exp_vout_b = v_out_i;
      tick();
    end
    chk_cnt++;
    if ({mr_a, ce_a, dn_a} !== {32'h6, 32'h8, 32'h80}) begin
      $display("FAIL init_timing_a got mrst=%h ce=%h done=%h want 6 8 80", mr_a, ce_a, dn_a);
    end else pass_cnt++;
    chk_cnt++;
    if ({mr_b, dn_b, b_steps, b_vout} !== {32'h6, 32'h20, 16'd1, exp_vout_b}) begin
      $display("FAIL init_b got mrst=%h done=%h steps=%0d vout=%h", mr_b, dn_b, b_steps, b_vout);
    end else pass_cnt++;
    chk_cnt++;
    if ({a_steps, a_vin, a_vout} !== {16'd1, -25'sd7, exp_vout_a}) begin
      $display("FAIL init_result_a got %h want %h", {a_steps, a_vin, a_vout},
               {16'd1, -25'sd7, exp_vout_a});
    end else pass_cnt++;
  endtask

  task automatic test_zero();
    logic [31:0] ce_ab = '0, dn_a = '0, bz_a = '0;
    launch(0, 1'b0, 25'sd5);
    for (int t = 1; t < 6; t++) begin
      ce_ab[t] = a_ce | b_ce; dn_a[t] = a_done; bz_a[t] = a_busy;
      v_out_i = DW'($urandom);
      if (t == 1) begin exp_vout_a = v_out_i; exp_vout_b = v_out_i; end
      tick();
    end
    chk_cnt++;
    if ({ce_ab, dn_a, bz_a} !== {32'h0, 32'h4, 32'h6}) begin
      $display("FAIL zero_timing got ce=%h done=%h busy=%h want 0 4 6", ce_ab, dn_a, bz_a);
    end else pass_cnt++;
    chk_cnt++;
    if ({a_steps, b_steps, a_vout, b_vout} !== {32'd0, exp_vout_a, exp_vout_b}) begin
      $display("FAIL zero_result got %h want %h", {a_steps, b_steps, a_vout, b_vout},
               {32'd0, exp_vout_a, exp_vout_b});
    end else pass_cnt++;
  endtask

  task automatic test_settle0();
    logic [31:0] ce_a = '0, dn_a = '0, ce_b = '0, dn_b = '0;
    launch(4, 1'b0, 25'sd9);
    for (int t = 1; t < 18; t++) begin
      ce_a[t] = a_ce; dn_a[t] = a_done; ce_b[t] = b_ce; dn_b[t] = b_done;
      v_out_i = DW'($urandom);
      if (t == 13) exp_vout_a = v_out_i;
      if (t == 5)  exp_vout_b = v_out_i;
      tick();
    end
    chk_cnt++;
    if ({ce_b, dn_b, b_steps} !== {32'h1E, 32'h40, 16'd4}) begin
      $display("FAIL settle0_b got ce=%h done=%h steps=%0d want 1e 40 4", ce_b, dn_b, b_steps);
    end else pass_cnt++;
    chk_cnt++;
    if ({ce_a, dn_a, a_steps} !== {32'h492, 32'h4000, 16'd4}) begin
      $display("FAIL settle0_a got ce=%h done=%h steps=%0d want 492 4000 4", ce_a, dn_a, a_steps);
    end else pass_cnt++;
  endtask

  task automatic test_abort();
    logic late = 1'b0;
    launch(5, 1'b0, 25'sd55);
    for (int t = 1; t <= 4; t++) begin
      if (t == 2) begin start_i = 1'b1; v_in_i = 25'sd999; n_steps_i = 16'd1; end
      if (t == 4) abort_i = 1'b1;
      v_out_i = DW'($urandom);
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
    end
    chk_cnt++;
    if ({a_abt, a_busy, a_done, a_steps, a_vin, a_vout} !== {3'b100, 16'd2, 25'sd55, exp_vout_a}) begin
      $display("FAIL abort_a got %h want %h", {a_abt, a_busy, a_done, a_steps, a_vin, a_vout},
               {3'b100, 16'd2, 25'sd55, exp_vout_a});
    end else pass_cnt++;
    chk_cnt++;
    if ({b_abt, b_busy, b_done, b_steps, b_vout} !== {3'b100, 16'd4, exp_vout_b}) begin
      $display("FAIL abort_b got %h want %h", {b_abt, b_busy, b_done, b_steps, b_vout},
               {3'b100, 16'd4, exp_vout_b});
    end else pass_cnt++;
    for (int t = 0; t < 12; t++) begin
      tick();
      late = late | a_done | b_done | a_abt | b_abt | a_busy | b_busy;
    end
    chk_cnt++;
    if (late !== 1'b0) begin
      $display("FAIL abort_quiet got activity=%b want 0", late);
    end else pass_cnt++;
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk_cnt++;
    if ({a_busy, a_abt, b_busy, b_abt} !== 4'b0000) begin
      $display("FAIL abort_priority got %b want 0000", {a_busy, a_abt, b_busy, b_abt});
    end else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    launch(3, 1'b0, 25'sd33);
    tick();
    rst = 1'b1;
    tick();
    chk_cnt++;
    if ({a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout,
         b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout}
        !== {5'b10000, 66'd0, 5'b10000, 66'd0}) begin
      $display("FAIL rst_mid got a=%h b=%h",
               {a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout},
               {b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout});
    end else pass_cnt++;
    tick();
    chk_cnt++;
    if ({a_mrst, b_mrst} !== 2'b11) begin
      $display("FAIL rst_hold_mrst got %b want 11", {a_mrst, b_mrst});
    end else pass_cnt++;
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({a_mrst, b_mrst, a_busy, b_busy, a_done, b_done} !== 6'b0) begin
      $display("FAIL rst_release got %b want 000000", {a_mrst, b_mrst, a_busy, b_busy, a_done, b_done});
    end else pass_cnt++;
    exp_vout_a = '0;
    exp_vout_b = '0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int n = int'($urandom_range(0, 5));
      bit init = 1'($urandom_range(0, 1));
      logic signed [DW-1:0] vin = DW'($urandom);
      int off = init ? 2 : 0;
      int dn_a = off + 2 + n * 3;
      int dn_b = off + 2 + n;
      logic signed [DW-1:0] cap_a = '0, cap_b = '0;
      logic [70:0] exp_v;
      launch(n, init, vin);
      for (int t = 1; t <= dn_a + 1; t++) begin
        exp_v = model(2, t, n, init, vin, (t > dn_a - 1) ? cap_a : exp_vout_a);
        chk_cnt++;
        if ({a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout} !== exp_v) begin
          $display("FAIL random_a run=%0d cycle=%0d got %h want %h", r, t,
                   {a_mrst, a_ce, a_busy, a_done, a_abt, a_steps, a_vin, a_vout}, exp_v);
        end else pass_cnt++;
        exp_v = model(0, t, n, init, vin, (t > dn_b - 1) ? cap_b : exp_vout_b);
        chk_cnt++;
        if ({b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout} !== exp_v) begin
          $display("FAIL random_b run=%0d cycle=%0d got %h want %h", r, t,
                   {b_mrst, b_ce, b_busy, b_done, b_abt, b_steps, b_vin, b_vout}, exp_v);
        end else pass_cnt++;
        // Disturb the latched inputs and poke start while both instances are busy.
        v_out_i   = DW'($urandom);
        v_in_i    = DW'($urandom);
        n_steps_i = CW'($urandom);
        start_i   = (t <= dn_b) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (t == dn_a - 1) cap_a = v_out_i;
        if (t == dn_b - 1) cap_b = v_out_i;
        tick();
        start_i = 1'b0;
      end
      exp_vout_a = cap_a;
      exp_vout_b = cap_b;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_init();
    test_zero();
    test_settle0();
    test_abort();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
